// File: rtl/ac97_pkg.sv
// Shared types and constants for the AC'97 codec register scheduler:
// FSM states, slot field positions and the built-in init table.
package ac97_pkg;

    typedef enum logic [2:0] {
        StWait,
        StInit,
        StIdle,
        StIssue,
        StWaitRsp
    } sched_state_e;

    localparam int unsigned SLOT_W       = 20;
    localparam int unsigned SLOT_RNW_BIT = 19;
    localparam int unsigned SLOT_ADDR_HI = 18;
    localparam int unsigned SLOT_ADDR_LO = 12;
    localparam int unsigned SLOT_DATA_HI = 19;
    localparam int unsigned SLOT_DATA_LO = 4;

    localparam int unsigned INIT_LEN_DEFAULT = 4;
    localparam int unsigned INIT_TABLE_LEN   = 4;
    localparam int unsigned INIT_IDX_W       = 3;

    // Entry 0 is the rightmost element.
    localparam logic [INIT_TABLE_LEN-1:0][6:0]  INIT_ADDR = {7'h2A, 7'h18, 7'h04, 7'h02};
    localparam logic [INIT_TABLE_LEN-1:0][15:0] INIT_DATA = {16'h0001, 16'h0808, 16'h0000, 16'h0000};

    function automatic logic [SLOT_W-1:0] addr_slot(input logic r_nw, input logic [6:0] addr);
        logic [SLOT_W-1:0] s;
        s = '0;
        s[SLOT_RNW_BIT] = r_nw;
        s[SLOT_ADDR_HI:SLOT_ADDR_LO] = addr;
        return s;
    endfunction

    function automatic logic [SLOT_W-1:0] data_slot(input logic [15:0] data);
        logic [SLOT_W-1:0] s;
        s = '0;
        s[SLOT_DATA_HI:SLOT_DATA_LO] = data;
        return s;
    endfunction

endpackage

// File: rtl/ac97_init_rom.sv
// Combinational lookup of the codec init table: index -> {addr[6:0], data[15:0]}.
// Indices past the end of the table return zero.
module ac97_init_rom
    import ac97_pkg::*;
(
    input  logic [INIT_IDX_W-1:0] idx,
    output logic [22:0]           entry
);

    always_comb begin
        entry = '0;
        for (int unsigned i = 0; i < INIT_TABLE_LEN; i++) begin
            if (idx == INIT_IDX_W'(i)) begin
                entry = {INIT_ADDR[i], INIT_DATA[i]};
            end
        end
    end

endmodule

// File: rtl/ac97_reg_sched.sv
// AC'97 codec register-access scheduler: warm-up wait, init table, then one host
// command per frame. Read replies and timeouts exist only with AC97_READBACK_EN.
module ac97_reg_sched
    import ac97_pkg::*;
#(
    parameter int unsigned WAIT_FRAMES    = 16,
    parameter int unsigned TIMEOUT_FRAMES = 4,
    parameter int unsigned INIT_LEN       = INIT_LEN_DEFAULT
) (
    input  logic              ac97_bitclk,
    input  logic              ac97_reset_b,
    input  logic              ac97_strobe,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_r_nw,
    input  logic [6:0]        cmd_addr,
    input  logic [15:0]       cmd_data,

    output logic              rsp_valid,
    output logic [15:0]       rsp_data,
    output logic              rsp_timeout,

    input  logic [SLOT_W-1:0] ac97_in_slot1,
    input  logic              ac97_in_slot1_valid,
    input  logic [SLOT_W-1:0] ac97_in_slot2,
    input  logic              ac97_in_slot2_valid,

    output logic [SLOT_W-1:0] ac97_out_slot1,
    output logic              ac97_out_slot1_valid,
    output logic [SLOT_W-1:0] ac97_out_slot2,
    output logic              ac97_out_slot2_valid,

    output logic              init_done
);

    localparam int unsigned WAIT_W = $clog2(WAIT_FRAMES) + 1;
    localparam int unsigned IDX_W  = $clog2(INIT_LEN) + 1;

    sched_state_e      state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [IDX_W-1:0]  init_idx_q, init_idx_d;
    logic              init_done_q, init_done_d;

    logic              hold_valid_q, hold_valid_d;
    logic              hold_r_nw_q, hold_r_nw_d;
    logic [6:0]        hold_addr_q, hold_addr_d;
    logic [15:0]       hold_data_q, hold_data_d;

    logic [SLOT_W-1:0] slot1_q, slot1_d;
    logic              slot1_valid_q, slot1_valid_d;
    logic [SLOT_W-1:0] slot2_q, slot2_d;
    logic              slot2_valid_q, slot2_valid_d;

    logic [22:0]       rom_entry;
    logic              handshake;

`ifdef AC97_READBACK_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_FRAMES) + 1;

    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              reply_match;
    logic              unused_in;

    assign reply_match = ac97_in_slot1_valid && ac97_in_slot2_valid &&
                         (ac97_in_slot1[SLOT_ADDR_HI:SLOT_ADDR_LO] == hold_addr_q);
    assign unused_in   = ^{ac97_in_slot1[SLOT_RNW_BIT], ac97_in_slot1[SLOT_ADDR_LO-1:0],
                           ac97_in_slot2[SLOT_DATA_LO-1:0]};
`else
    logic              unused_in;

    assign unused_in = ^{ac97_in_slot1, ac97_in_slot1_valid, ac97_in_slot2, ac97_in_slot2_valid};
`endif

    ac97_init_rom u_init_rom (
        .idx   (INIT_IDX_W'(init_idx_q)),
        .entry (rom_entry)
    );

    assign cmd_ready = init_done_q && !hold_valid_q;
    assign handshake = cmd_valid && cmd_ready;

    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        init_idx_d    = init_idx_q;
        init_done_d   = init_done_q;
        hold_valid_d  = hold_valid_q;
        hold_r_nw_d   = hold_r_nw_q;
        hold_addr_d   = hold_addr_q;
        hold_data_d   = hold_data_q;
        slot1_d       = slot1_q;
        slot1_valid_d = slot1_valid_q;
        slot2_d       = slot2_q;
        slot2_valid_d = slot2_valid_q;
        rsp_valid     = 1'b0;
        rsp_data      = '0;
        rsp_timeout   = 1'b0;
`ifdef AC97_READBACK_EN
        tmo_cnt_d     = tmo_cnt_q;
`endif

        // cmd_ready is low whenever the holding register is busy, so a load never
        // collides with a release below.
        if (handshake) begin
            hold_valid_d = 1'b1;
            hold_r_nw_d  = cmd_r_nw;
            hold_addr_d  = cmd_addr;
            hold_data_d  = cmd_data;
        end

        unique case (state_q)
            StWait: begin
                if (ac97_strobe) begin
                    if (wait_cnt_q == WAIT_W'(WAIT_FRAMES - 1)) begin
                        wait_cnt_d = '0;
                        state_d    = StInit;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end

            StInit: begin
                if (ac97_strobe) begin
                    if (init_idx_q == IDX_W'(INIT_LEN)) begin
                        slot1_d       = '0;
                        slot1_valid_d = 1'b0;
                        slot2_d       = '0;
                        slot2_valid_d = 1'b0;
                        init_done_d   = 1'b1;
                        state_d       = StIdle;
                    end else begin
                        slot1_d       = addr_slot(1'b0, rom_entry[22:16]);
                        slot1_valid_d = 1'b1;
                        slot2_d       = data_slot(rom_entry[15:0]);
                        slot2_valid_d = 1'b1;
                        init_idx_d    = init_idx_q + IDX_W'(1);
                    end
                end
            end

            StIdle: begin
                if (ac97_strobe && hold_valid_q) begin
                    slot1_d       = addr_slot(hold_r_nw_q, hold_addr_q);
                    slot1_valid_d = 1'b1;
                    slot2_d       = hold_r_nw_q ? '0 : data_slot(hold_data_q);
                    slot2_valid_d = !hold_r_nw_q;
                    state_d       = StIssue;
                end
            end

            StIssue: begin
                if (ac97_strobe) begin
                    slot1_d       = '0;
                    slot1_valid_d = 1'b0;
                    slot2_d       = '0;
                    slot2_valid_d = 1'b0;
`ifdef AC97_READBACK_EN
                    if (hold_r_nw_q) begin
                        tmo_cnt_d = TMO_W'(TIMEOUT_FRAMES);
                        state_d   = StWaitRsp;
                    end else begin
                        hold_valid_d = 1'b0;
                        state_d      = StIdle;
                    end
`else
                    hold_valid_d = 1'b0;
                    state_d      = StIdle;
`endif
                end
            end

`ifdef AC97_READBACK_EN
            StWaitRsp: begin
                if (ac97_strobe) begin
                    if (reply_match) begin
                        rsp_valid    = 1'b1;
                        rsp_data     = ac97_in_slot2[SLOT_DATA_HI:SLOT_DATA_LO];
                        hold_valid_d = 1'b0;
                        state_d      = StIdle;
                    end else if (tmo_cnt_q == TMO_W'(1)) begin
                        tmo_cnt_d    = '0;
                        rsp_valid    = 1'b1;
                        rsp_data     = 16'hFFFF;
                        rsp_timeout  = 1'b1;
                        hold_valid_d = 1'b0;
                        state_d      = StIdle;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                    end
                end
            end
`endif

            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge ac97_bitclk or negedge ac97_reset_b) begin
        if (!ac97_reset_b) begin
            state_q       <= StWait;
            wait_cnt_q    <= '0;
            init_idx_q    <= '0;
            init_done_q   <= 1'b0;
            hold_valid_q  <= 1'b0;
            hold_r_nw_q   <= 1'b0;
            hold_addr_q   <= '0;
            hold_data_q   <= '0;
            slot1_q       <= '0;
            slot1_valid_q <= 1'b0;
            slot2_q       <= '0;
            slot2_valid_q <= 1'b0;
`ifdef AC97_READBACK_EN
            tmo_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            init_idx_q    <= init_idx_d;
            init_done_q   <= init_done_d;
            hold_valid_q  <= hold_valid_d;
            hold_r_nw_q   <= hold_r_nw_d;
            hold_addr_q   <= hold_addr_d;
            hold_data_q   <= hold_data_d;
            slot1_q       <= slot1_d;
            slot1_valid_q <= slot1_valid_d;
            slot2_q       <= slot2_d;
            slot2_valid_q <= slot2_valid_d;
`ifdef AC97_READBACK_EN
            tmo_cnt_q     <= tmo_cnt_d;
`endif
        end
    end

    assign ac97_out_slot1       = slot1_q;
    assign ac97_out_slot1_valid = slot1_valid_q;
    assign ac97_out_slot2       = slot2_q;
    assign ac97_out_slot2_valid = slot2_valid_q;
    assign init_done            = init_done_q;

endmodule

// File: tb/tb_ac97_reg_sched.sv
// Directed bench for ac97_reg_sched: warm-up/init frames, writes, reads (reply and
// timeout when AC97_READBACK_EN is defined), strobe-coincident handshake, mid-read reset.
module tb_ac97_reg_sched;

    logic        ac97_bitclk;
    logic        ac97_reset_b;
    logic        ac97_strobe;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_r_nw;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic [19:0] ac97_in_slot1;
    logic        ac97_in_slot1_valid;
    logic [19:0] ac97_in_slot2;
    logic        ac97_in_slot2_valid;
    logic [19:0] ac97_out_slot1;
    logic        ac97_out_slot1_valid;
    logic [19:0] ac97_out_slot2;
    logic        ac97_out_slot2_valid;
    logic        init_done;

    int n_tests = 0;
    int n_fail  = 0;

    // Expected {rsp_timeout, rsp_data}, pushed just before the strobe that must complete a read.
    logic [16:0] exp_q[$];

    logic [6:0]  t_addr [4] = '{7'h02, 7'h04, 7'h18, 7'h2A};
    logic [15:0] t_data [4] = '{16'h0000, 16'h0000, 16'h0808, 16'h0001};

    ac97_reg_sched #(
        .WAIT_FRAMES    (16),
        .TIMEOUT_FRAMES (4),
        .INIT_LEN       (4)
    ) dut (
        .ac97_bitclk          (ac97_bitclk),
        .ac97_reset_b         (ac97_reset_b),
        .ac97_strobe          (ac97_strobe),
        .cmd_valid            (cmd_valid),
        .cmd_ready            (cmd_ready),
        .cmd_r_nw             (cmd_r_nw),
        .cmd_addr             (cmd_addr),
        .cmd_data             (cmd_data),
        .rsp_valid            (rsp_valid),
        .rsp_data             (rsp_data),
        .rsp_timeout          (rsp_timeout),
        .ac97_in_slot1        (ac97_in_slot1),
        .ac97_in_slot1_valid  (ac97_in_slot1_valid),
        .ac97_in_slot2        (ac97_in_slot2),
        .ac97_in_slot2_valid  (ac97_in_slot2_valid),
        .ac97_out_slot1       (ac97_out_slot1),
        .ac97_out_slot1_valid (ac97_out_slot1_valid),
        .ac97_out_slot2       (ac97_out_slot2),
        .ac97_out_slot2_valid (ac97_out_slot2_valid),
        .init_done            (init_done)
    );

    initial ac97_bitclk = 1'b0;
    always #5 ac97_bitclk = ~ac97_bitclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {2'b0, ac97_out_slot1, ac97_out_slot1_valid, ac97_out_slot2, ac97_out_slot2_valid,
                cmd_ready, init_done, rsp_valid, rsp_data, rsp_timeout};
    endfunction

    task automatic check_slots(input string tag, input logic [19:0] s1, input logic v1,
                               input logic [19:0] s2, input logic v2);
        chk(tag, {ac97_out_slot1, ac97_out_slot1_valid, ac97_out_slot2, ac97_out_slot2_valid},
            {s1, v1, s2, v2});
    endtask

    // Three quiet cycles then one strobe cycle; returns #1 after the strobe edge.
    task automatic frame();
        repeat (3) begin
            @(posedge ac97_bitclk);
            #1;
        end
        ac97_strobe = 1'b1;
        @(posedge ac97_bitclk);
        #1;
        ac97_strobe = 1'b0;
    endtask

    task automatic send_cmd(input logic r_nw, input logic [6:0] addr, input logic [15:0] data);
        cmd_valid = 1'b1;
        cmd_r_nw  = r_nw;
        cmd_addr  = addr;
        cmd_data  = data;
        chk("cmd_ready_before_hs", 64'(cmd_ready), 64'd1);
        @(posedge ac97_bitclk);
        #1;
        cmd_valid = 1'b0;
        chk("cmd_ready_after_hs", 64'(cmd_ready), 64'd0);
    endtask

    task automatic run_wait_init();
        for (int f = 0; f < 16; f++) begin
            frame();
            chk("wait_quiet",
                64'({ac97_out_slot1_valid, ac97_out_slot2_valid, init_done, cmd_ready}), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            frame();
            check_slots("init_entry", {1'b0, t_addr[i], 12'h000}, 1'b1, {t_data[i], 4'h0}, 1'b1);
            chk("init_not_done", 64'(init_done), 64'd0);
        end
        frame();
        check_slots("init_clear", 20'h0, 1'b0, 20'h0, 1'b0);
        chk("init_done_ready", 64'({init_done, cmd_ready}), 64'd3);
    endtask

    always @(negedge ac97_bitclk) begin
        if (rsp_valid !== 1'b0) begin
            if (exp_q.size() == 0) begin
                chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                chk("rsp_payload", 64'({rsp_timeout, rsp_data}), 64'(exp_q.pop_front()));
                chk("rsp_on_strobe", 64'(ac97_strobe), 64'd1);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        ac97_reset_b        = 1'b0;
        ac97_strobe         = 1'b0;
        cmd_valid           = 1'b0;
        cmd_r_nw            = 1'b0;
        cmd_addr            = '0;
        cmd_data            = '0;
        ac97_in_slot1       = '0;
        ac97_in_slot1_valid = 1'b0;
        ac97_in_slot2       = '0;
        ac97_in_slot2_valid = 1'b0;

        repeat (3) @(posedge ac97_bitclk);
        #1;
        chk("reset_outputs", all_outs(), 64'd0);
        ac97_reset_b = 1'b1;

        run_wait_init();

        // Write 0x2C <- 0xBB80: exactly one frame on the slots, cmd_ready low meanwhile.
        send_cmd(1'b0, 7'h2C, 16'hBB80);
        frame();
        check_slots("wr_issue", 20'h2C000, 1'b1, 20'hBB800, 1'b1);
        chk("wr_ready_low", 64'(cmd_ready), 64'd0);
        @(posedge ac97_bitclk);
        #1;
        check_slots("wr_hold_midframe", 20'h2C000, 1'b1, 20'hBB800, 1'b1);
        frame();
        check_slots("wr_clear", 20'h0, 1'b0, 20'h0, 1'b0);
        chk("wr_ready_back", 64'(cmd_ready), 64'd1);

        // Read 0x26 with a matching reply on the second frame.
        send_cmd(1'b1, 7'h26, 16'h0000);
        frame();
        check_slots("rd26_issue", 20'hA6000, 1'b1, 20'h0, 1'b0);
        frame();
        check_slots("rd26_clear", 20'h0, 1'b0, 20'h0, 1'b0);
`ifdef AC97_READBACK_EN
        chk("rd26_ready_wait", 64'(cmd_ready), 64'd0);
        exp_q.push_back({1'b0, 16'h000F});
`else
        chk("rd26_ready_wait", 64'(cmd_ready), 64'd1);
`endif
        ac97_in_slot1       = 20'h26000;
        ac97_in_slot1_valid = 1'b1;
        ac97_in_slot2       = 20'h000F0;
        ac97_in_slot2_valid = 1'b1;
        frame();
        ac97_in_slot1_valid = 1'b0;
        ac97_in_slot2_valid = 1'b0;
        chk("rd26_rsp_seen", 64'(exp_q.size()), 64'd0);
        chk("rd26_ready_back", 64'(cmd_ready), 64'd1);

        // Read 0x7C: a non-matching reply at the second frame, then silence until timeout.
        send_cmd(1'b1, 7'h7C, 16'h0000);
        frame();
        check_slots("rd7c_issue", 20'hFC000, 1'b1, 20'h0, 1'b0);
        frame();
        ac97_in_slot1       = 20'h26000;
        ac97_in_slot1_valid = 1'b1;
        ac97_in_slot2       = 20'h12340;
        ac97_in_slot2_valid = 1'b1;
        frame();
        ac97_in_slot1_valid = 1'b0;
        ac97_in_slot2_valid = 1'b0;
        frame();
        frame();
`ifdef AC97_READBACK_EN
        chk("rd7c_ready_wait", 64'(cmd_ready), 64'd0);
        exp_q.push_back({1'b1, 16'hFFFF});
`else
        chk("rd7c_ready_wait", 64'(cmd_ready), 64'd1);
`endif
        frame();
        chk("rd7c_timeout_seen", 64'(exp_q.size()), 64'd0);
        chk("rd7c_ready_back", 64'(cmd_ready), 64'd1);

        // Handshake on a strobe cycle issues at the next strobe; a second command waits.
        repeat (2) begin
            @(posedge ac97_bitclk);
            #1;
        end
        cmd_valid   = 1'b1;
        cmd_r_nw    = 1'b0;
        cmd_addr    = 7'h10;
        cmd_data    = 16'h1234;
        ac97_strobe = 1'b1;
        @(posedge ac97_bitclk);
        #1;
        ac97_strobe = 1'b0;
        check_slots("strobe_hs_not_issued", 20'h0, 1'b0, 20'h0, 1'b0);
        chk("strobe_hs_ready_low", 64'(cmd_ready), 64'd0);
        cmd_addr = 7'h12;
        cmd_data = 16'h5678;
        frame();
        check_slots("strobe_hs_issue", 20'h10000, 1'b1, 20'h12340, 1'b1);
        chk("second_held_off", 64'(cmd_ready), 64'd0);
        frame();
        check_slots("strobe_hs_clear", 20'h0, 1'b0, 20'h0, 1'b0);
        chk("second_ready_after_release", 64'(cmd_ready), 64'd1);
        @(posedge ac97_bitclk);
        #1;
        cmd_valid = 1'b0;
        chk("second_accepted", 64'(cmd_ready), 64'd0);
        frame();
        check_slots("second_issue", 20'h12000, 1'b1, 20'h56780, 1'b1);
        frame();
        check_slots("second_clear", 20'h0, 1'b0, 20'h0, 1'b0);

        // Reset while a read waits for its reply: no response, full restart.
        send_cmd(1'b1, 7'h26, 16'h0000);
        frame();
        frame();
        ac97_in_slot1       = 20'h26000;
        ac97_in_slot1_valid = 1'b1;
        ac97_in_slot2       = 20'h000F0;
        ac97_in_slot2_valid = 1'b1;
        @(posedge ac97_bitclk);
        #3;
        ac97_reset_b = 1'b0;
        #1;
        chk("midread_reset_outputs", all_outs(), 64'd0);
        frame();
        frame();
        chk("in_reset_outputs", all_outs(), 64'd0);
        ac97_reset_b        = 1'b1;
        ac97_in_slot1_valid = 1'b0;
        ac97_in_slot2_valid = 1'b0;

        run_wait_init();

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
